memaccess: RTL and testbench

// LC3 memory-access stage between execute and writeback. Performs LD/LDR, LDI, ST/STR
// and STI against a variable-latency data memory with a req/ready handshake. For loads
// it returns memout plus a one-cycle enable_writeback pulse for the writeback stage.

---
 rtl/memaccess.sv | 137 +++++++++++++
 tb/tb_memaccess.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/memaccess.sv
// memaccess: LC3 memory-access stage between execute and writeback.
// Runs LD/LDR, LDI, ST/STR and STI against a variable-latency data memory
// (req/ready handshake). Indirect ops make two back-to-back accesses, the
// first one fetching the pointer. Every access has its own wait timeout.
// Ports:
//   clk, rst                    clock (rising edge), async active-low reset
//   start, mem_op, M_Addr, M_Data  operation request, sampled in IDLE only
//   d_req, d_we, d_addr, d_din  memory request side (stable until d_ready)
//   d_dout, d_ready             memory response side
//   memout                      last loaded value, held between loads
//   busy, done, enable_writeback, err  status; done/ewb/err are 1-cycle pulses
module memaccess #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mem_op,
  input  logic [15:0] M_Addr,
  input  logic [15:0] M_Data,
  output logic        d_req,
  output logic        d_we,
  output logic [15:0] d_addr,
  output logic [15:0] d_din,
  input  logic [15:0] d_dout,
  input  logic        d_ready,
  output logic [15:0] memout,
  output logic        busy,
  output logic        done,
  output logic        enable_writeback,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, FIN} st_t;

  // mem_op encoding: bit1 = store, bit0 = indirect
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  st_t         state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [15:0] ind_q, ind_d;
  logic [15:0] memout_q, memout_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        tmo;

  // d_ready in the last allowed cycle still completes the access
  assign tmo = (TIMEOUT != 0) && (cnt_q == TMO_LAST) && !d_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      ind_q    <= '0;
      memout_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ind_q    <= ind_d;
      memout_q <= memout_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    ind_d    = ind_q;
    memout_d = memout_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: if (start) begin
        op_d    = mem_op;
        addr_d  = M_Addr;
        data_d  = M_Data;
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = ACC1;
      end
      ACC1: begin
        if (d_ready) begin
          cnt_d = '0;
          if (op_q[0]) begin
            ind_d   = d_dout;
            state_d = ACC2;
          end else begin
            if (!op_q[1]) memout_d = d_dout;
            state_d = FIN;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACC2: begin
        if (d_ready) begin
          if (!op_q[1]) memout_d = d_dout;
          state_d = FIN;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Everything below is decoded from registers, so reset clears it at once
  assign d_req            = (state_q == ACC1) || (state_q == ACC2);
  // The pointer fetch of STI is a read; only the final store access writes
  assign d_we             = d_req && op_q[1] && ((state_q == ACC2) || !op_q[0]);
  assign d_addr           = (state_q == ACC2) ? ind_q : addr_q;
  assign d_din            = data_q;
  assign memout           = memout_q;
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == FIN);
  assign enable_writeback = (state_q == FIN) && !err_q && !op_q[1];
  assign err              = (state_q == FIN) && err_q;

endmodule

// File: tb/tb_memaccess.sv
module tb_memaccess;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mem_op = '0;
  logic [15:0] M_Addr = '0, M_Data = '0;
  logic        d_req, d_we;
  logic [15:0] d_addr, d_din;
  logic [15:0] d_dout = '0;
  logic        d_ready = 1'b0;
  logic [15:0] memout;
  logic        busy, done, enable_writeback, err;

  memaccess #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_op(mem_op), .M_Addr(M_Addr),
    .M_Data(M_Data), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_din(d_din),
    .d_dout(d_dout), .d_ready(d_ready), .memout(memout), .busy(busy), .done(done),
    .enable_writeback(enable_writeback), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory seen by the DUT and the reference model's own copy
  bit [15:0] mem [65536];
  bit [15:0] ref_mem [65536];
  logic [15:0] ref_mout = '0;

  typedef struct { bit err; bit ew; logic [15:0] mout; int cyc; } exp_t;
  typedef struct { bit we; logic [15:0] addr; logic [15:0] din; } acc_t;
  exp_t sb[$];
  acc_t eacc[$];
  int   wq[$];   // wait cycles for each access the DUT will make

  // ---------------- memory responder ----------------
  int   acc_cnt = 0, cur_w = 0;
  bit   have_w = 0;
  acc_t lat;
  always @(negedge clk) begin
    if (rst && d_req) begin
      if (!have_w) begin
        if (wq.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_access: addr %0h we %0b", d_addr, d_we);
          cur_w = 0;
        end else cur_w = wq.pop_front();
        have_w = 1; acc_cnt = 0;
        lat = '{d_we, d_addr, d_din};
      end else begin
        chk("req_stable_we_addr", {15'd0, d_we, d_addr}, {15'd0, lat.we, lat.addr});
        if (lat.we) chk("req_stable_din", {16'd0, d_din}, {16'd0, lat.din});
      end
      if (acc_cnt == cur_w) begin
        d_ready = 1'b1;
        d_dout  = mem[d_addr];
        if (d_we) mem[d_addr] = d_din;
        if (eacc.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL access_extra: addr %0h", d_addr);
        end else begin
          acc_t e;
          e = eacc.pop_front();
          chk("access_we", {31'd0, d_we}, {31'd0, e.we});
          chk("access_addr", {16'd0, d_addr}, {16'd0, e.addr});
          if (e.we) chk("access_din", {16'd0, d_din}, {16'd0, e.din});
        end
        have_w = 0;
      end else begin
        d_ready = 1'b0;
        d_dout  = 16'($urandom);
        acc_cnt++;
      end
    end else begin
      d_ready = 1'b0;
      have_w  = 0;
      d_dout  = 16'($urandom);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL done_unexpected: t=%0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("err", {31'd0, err}, {31'd0, e.err});
        chk("enable_writeback", {31'd0, enable_writeback}, {31'd0, e.ew});
        chk("memout_at_done", {16'd0, memout}, {16'd0, e.mout});
        chk("done_cycle", cyc, e.cyc);
      end
    end else if (rst && (enable_writeback || err)) begin
      nvec++; nerr++;
      $display("FAIL pulse_without_done: ewb %0b err %0b", enable_writeback, err);
    end
  end

  // ---------------- reference model + driver ----------------
  // Called at a negedge: predicts the whole operation, then drives it and
  // keeps poking junk starts until done shows.
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                       input int w1, input int w2);
    exp_t e;
    int k;
    bit seen;
    logic [15:0] v, ia;
    k = cyc;
    e.err = 0; e.ew = 0;
    wq.push_back(w1);
    if (w1 >= TMO) begin
      e.err = 1; e.cyc = k + 1 + TMO;
    end else begin
      eacc.push_back('{op == 2'd2, a, d});
      v = ref_mem[a];
      case (op)
        2'd0: begin ref_mout = v; e.ew = 1; e.cyc = k + w1 + 2; end
        2'd2: begin ref_mem[a] = d; e.cyc = k + w1 + 2; end
        default: begin
          ia = v;
          wq.push_back(w2);
          if (w2 >= TMO) begin
            e.err = 1; e.cyc = k + w1 + 2 + TMO;
          end else begin
            eacc.push_back('{op == 2'd3, ia, d});
            if (op == 2'd1) begin ref_mout = ref_mem[ia]; e.ew = 1; end
            else ref_mem[ia] = d;
            e.cyc = k + w1 + w2 + 3;
          end
        end
      endcase
    end
    e.mout = ref_mout;
    sb.push_back(e);
    start = 1'b1; mem_op = op; M_Addr = a; M_Data = d;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) begin start = 1'b0; seen = 1; break; end
      start  = ($urandom_range(0, 2) == 0);
      mem_op = 2'($urandom);
      M_Addr = 16'($urandom);
      M_Data = 16'($urandom);
    end
    start = 1'b0;
    if (!seen) begin
      nvec++; nerr++;
      $display("FAIL done_timeout: op %0d addr %0h", op, a);
    end
    @(negedge clk);
    chk("memout_hold_idle", {16'd0, memout}, {16'd0, ref_mout});
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 5) == 0) ? int'($urandom_range(TMO, TMO + 2))
                                       : int'($urandom_range(0, TMO - 1));
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16'h3000] = 16'h5000; ref_mem[16'h3000] = 16'h5000;
    mem[16'h5000] = 16'h00AA; ref_mem[16'h5000] = 16'h00AA;

    #12;
    chk("rst_d_req", {31'd0, d_req}, 32'd0);
    chk("rst_outs", {26'd0, d_we, busy, done, enable_writeback, err, 1'b0},  32'd0);
    chk("rst_addr_din", {d_addr, d_din}, 32'd0);
    chk("rst_memout", {16'd0, memout}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // Directed: LDI, LD, ST with waits, STI, timeouts
    issue(2'd1, 16'h3000, 16'h0000, 0, 0);
    mem[16'h3000] = 16'hBEEF; ref_mem[16'h3000] = 16'hBEEF;
    issue(2'd0, 16'h3000, 16'h0000, 0, 0);
    issue(2'd2, 16'h4000, 16'h1234, 3, 0);
    mem[16'h3000] = 16'h6000; ref_mem[16'h3000] = 16'h6000;
    issue(2'd3, 16'h3000, 16'h7777, 1, 2);
    issue(2'd0, 16'h4000, 16'h0000, TMO - 1, 0);
    issue(2'd0, 16'h4000, 16'h0000, TMO + 3, 0);
    issue(2'd1, 16'h3000, 16'h0000, 0, TMO);
    issue(2'd0, 16'h6000, 16'h0000, 0, 0);

    // Reset while LDI sits in its second access
    mem[16'h3000] = 16'h5000; ref_mem[16'h3000] = 16'h5000;
    wq.push_back(0); wq.push_back(TMO - 1);
    eacc.push_back('{1'b0, 16'h3000, 16'h0000});
    start = 1'b1; mem_op = 2'd1; M_Addr = 16'h3000; M_Data = 16'h0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("acc2_req_addr", {15'd0, d_req, d_addr}, {15'd0, 1'b1, 16'h5000});
    rst = 1'b0;
    #1;
    chk("midrst_d_req", {31'd0, d_req}, 32'd0);
    chk("midrst_outs", {27'd0, d_we, busy, done, enable_writeback, err}, 32'd0);
    chk("midrst_addr_din", {d_addr, d_din}, 32'd0);
    chk("midrst_memout", {16'd0, memout}, 32'd0);
    wq.delete(); eacc.delete();
    ref_mout = '0;
    @(negedge clk); @(negedge clk); rst = 1'b1;
    @(negedge clk);
    issue(2'd0, 16'h5000, 16'h0000, 1, 0);

    // Randomized
    for (int n = 0; n < 150; n++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'h3000, 16'h3007)) : 16'($urandom);
      issue(2'($urandom), a, 16'($urandom), rand_wait(), rand_wait());
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    chk("wq_empty", wq.size(), 32'd0);
    chk("eacc_empty", eacc.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
